// File: rtl/ro_meas_pkg.sv
// Shared types, default constants and saturating-increment helper for the
// ring-oscillator frequency meter.
package ro_meas_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2,
      HOLD    = 2'd3
   } measState_t;

   localparam int unsigned DEF_N_RO          = 2;
   localparam int unsigned DEF_CNT_W         = 16;
   localparam int unsigned DEF_GATE_CYCLES   = 1024;
   localparam int unsigned DEF_SETTLE_CYCLES = 16;

   // Widest counter the helper can saturate; callers cast to their own width.
   localparam int unsigned SAT_W = 32;

   function automatic logic [SAT_W-1:0] satInc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] maxVal);
      return (value >= maxVal) ? maxVal : value + SAT_W'(1);
   endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchroniser plus previous-sample flop producing a rising-edge
// pulse; load realigns the previous sample without emitting a pulse.
module ro_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   input  logic load,
   input  logic en,
   output logic edgePulse
);

   logic sync1, sync2, prev;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (load || en) prev <= sync2;
      end
   end

   assign edgePulse = en && sync2 && !prev;

endmodule

// File: rtl/ro_freq_meter.sv
// Gated rising-edge counter for a selectable ring oscillator: settle, count
// over a fixed window, then hold the result behind a valid/ready handshake.
module ro_freq_meter
   import ro_meas_pkg::*;
#(
   parameter  int unsigned N_RO          = DEF_N_RO,
   parameter  int unsigned CNT_W         = DEF_CNT_W,
   parameter  int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
   parameter  int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   localparam int unsigned SEL_W         = (N_RO > 1) ? $clog2(N_RO) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [SEL_W-1:0] roSel,
   input  logic [N_RO-1:0]  roIn,
   output logic [N_RO-1:0]  roEn,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             valid,
   input  logic             ready
);

   localparam int unsigned MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CYC_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
   localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [SEL_W:0]   N_RO_V      = (SEL_W + 1)'(N_RO);

   measState_t       state, stateNext;
   logic [SEL_W-1:0] selQ;
   logic [CYC_W-1:0] cycCnt;
   logic             accept, lastSettle, measuring, edgePulse;

   assign accept     = start && ({1'b0, roSel} < N_RO_V);
   assign lastSettle = (state == SETTLE) && (cycCnt == SETTLE_LAST);
   assign measuring  = (state == MEASURE);

   // The mux feeds the synchroniser; the settle time flushes any stale sample.
   ro_sync_edge uSyncEdge (
      .clk       (clk),
      .reset     (reset),
      .din       (roIn[selQ]),
      .load      (lastSettle),
      .en        (measuring),
      .edgePulse (edgePulse)
   );

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      stateNext = state;
      roEn      = '0;
      busy      = (state != IDLE);
      valid     = (state == HOLD);
      unique case (state)
         IDLE:    if (accept) stateNext = SETTLE;
         SETTLE: begin
            roEn[selQ] = 1'b1;
            if (cycCnt == SETTLE_LAST) stateNext = MEASURE;
         end
         MEASURE: begin
            roEn[selQ] = 1'b1;
            if (cycCnt == GATE_LAST) stateNext = HOLD;
         end
         HOLD:    if (ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         selQ     <= '0;
         cycCnt   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         state <= stateNext;
         if (state == IDLE && accept) selQ <= roSel;

         if (stateNext != state)                    cycCnt <= '0;
         else if (state == SETTLE || measuring)     cycCnt <= cycCnt + CYC_W'(1);

         // Result clears on window open and is otherwise only touched by counted edges.
         if (lastSettle) begin
            count    <= '0;
            overflow <= 1'b0;
         end else if (measuring && edgePulse) begin
            count <= CNT_W'(satInc(SAT_W'(count), SAT_W'(CNT_MAX)));
            if (count == CNT_MAX) overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Scoreboarded bench for ro_freq_meter: randomized RO periods against an
// ideal edges-per-window model, plus reset, backpressure, saturation and index cases.
`timescale 1ns/1ps
module tb_ro_freq_meter;

   localparam int unsigned GATE   = 64;
   localparam int unsigned SETTLE = 16;
   localparam int unsigned CLK_NS = 10;

   typedef struct {
      int unsigned startCyc;
      int unsigned lo;
      int unsigned hi;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset, start, roSel, ready;
   logic        ro0 = 1'b0, ro1 = 1'b0;
   logic [1:0]  roIn, roEn;
   logic        busy, overflow, valid;
   logic [15:0] count;
   assign roIn = {ro1, ro0};

   logic        satStart, satReady, satRo = 1'b0;
   logic [1:0]  satRoIn, satRoEn;
   logic        satBusy, satOverflow, satValid;
   logic [3:0]  satCount;
   assign satRoIn = {1'b0, satRo};

   logic        invStart, invReady;
   logic [1:0]  invSel;
   logic [2:0]  invRoIn, invRoEn;
   logic        invBusy, invOverflow, invValid;
   logic [15:0] invCount;
   assign invRoIn = 3'b000;

   ro_freq_meter #(.N_RO(2), .CNT_W(16), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .reset(reset), .start(start), .roSel(roSel), .roIn(roIn), .roEn(roEn),
      .busy(busy), .count(count), .overflow(overflow), .valid(valid), .ready(ready));

   ro_freq_meter #(.N_RO(2), .CNT_W(4), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE)) dutSat (
      .clk(clk), .reset(reset), .start(satStart), .roSel(1'b0), .roIn(satRoIn), .roEn(satRoEn),
      .busy(satBusy), .count(satCount), .overflow(satOverflow), .valid(satValid), .ready(satReady));

   ro_freq_meter #(.N_RO(3), .CNT_W(16), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE)) dutInv (
      .clk(clk), .reset(reset), .start(invStart), .roSel(invSel), .roIn(invRoIn), .roEn(invRoEn),
      .busy(invBusy), .count(invCount), .overflow(invOverflow), .valid(invValid), .ready(invReady));

   // Free-running oscillators, phase-offset from the clock edges.
   int unsigned halfNs0 = 40, halfNs1 = 40;
   initial begin #3; forever begin #(halfNs0); ro0 = ~ro0; end end
   initial begin #7; forever begin #(halfNs1); ro1 = ~ro1; end end
   initial begin #3; forever begin #10; satRo = ~satRo; end end

   int   errors = 0, checks = 0;
   exp_t sbq[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic checkRange(input string name, input logic [31:0] got,
                             input int unsigned lo, input int unsigned hi);
      checks++;
      if (got < lo || got > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, got, lo, hi, $time);
      end
   endtask

   // Ideal model: rising edges of a square wave of period 2*half over GATE clock periods, +/-1.
   function automatic exp_t model(input int unsigned startCyc, input int unsigned half);
      exp_t        e;
      int unsigned window = GATE * CLK_NS;
      int unsigned period = 2 * half;
      int unsigned n      = window / period;
      e.startCyc = startCyc;
      e.lo       = (n > 0) ? n - 1 : 0;
      e.hi       = n + ((window % period) != 0 ? 1 : 0) + 1;
      return e;
   endfunction

   // Scoreboard monitor: pops one expectation per completed handshake.
   int unsigned firstValidCyc = 0;
   logic        holdSeen = 1'b0;
   int unsigned ro1Count = 0, onehotBad = 0;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         holdSeen = 1'b0;
      end else begin
         if (valid && !holdSeen) begin
            holdSeen      = 1'b1;
            firstValidCyc = cyc;
         end
         if (valid && ready) begin
            if (sbq.size() == 0) begin
               check("unexpected_result", 32'(count), 32'hFFFF_FFFF);
            end else begin
               e = sbq.pop_front();
               check("latency", firstValidCyc - e.startCyc, SETTLE + GATE + 1);
               checkRange("count", 32'(count), e.lo, e.hi);
               check("overflow", 32'(overflow), 0);
            end
            holdSeen = 1'b0;
         end
         if (roEn[1]) ro1Count++;
         if ((roEn & (roEn - 2'd1)) != 2'b00) onehotBad++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic startMeas(input logic sel);
      sbq.push_back(model(cyc, sel ? halfNs1 : halfNs0));
      roSel = sel;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic waitIdle(input string name, input int maxCyc);
      for (int i = 0; i < maxCyc && busy; i++) tick(1);
      check(name, 32'(busy), 0);
   endtask

   initial begin
      logic [17:0] held;
      int unsigned ro1Before;
      int unsigned validAfter;

      reset = 1'b1; start = 1'b0; roSel = 1'b0; ready = 1'b1;
      satStart = 1'b0; satReady = 1'b1; invStart = 1'b0; invSel = 2'd0; invReady = 1'b1;
      tick(3);
      check("rst_count", 32'(count), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_roEn", 32'(roEn), 0);
      check("rst_overflow", 32'(overflow), 0);
      reset = 1'b0;
      tick(2);

      // Basic: RO1 period 8 clocks.
      startMeas(1'b1);
      tick(4);
      check("roEn_settle", 32'(roEn), 32'b10);
      tick(30);
      check("roEn_measure", 32'(roEn), 32'b10);
      waitIdle("basic_done", 200);
      check("roEn_idle", 32'(roEn), 0);

      // Selection: RO0 period 16 clocks, RO1 period 4 clocks, RO1 must stay disabled.
      halfNs0 = 80; halfNs1 = 20;
      tick(12);
      ro1Before = ro1Count;
      startMeas(1'b0);
      waitIdle("sel_done", 200);
      check("roEn1_unused", ro1Count - ro1Before, 0);

      // Backpressure with an ignored start during the hold.
      halfNs1 = 40;
      tick(10);
      ready = 1'b0;
      startMeas(1'b1);
      for (int i = 0; i < 200 && !valid; i++) tick(1);
      check("bp_valid_seen", 32'(valid), 1);
      held = {valid, busy, count};
      for (int i = 0; i < 20; i++) begin
         start = (i == 10);
         tick(1);
         check("bp_hold", 32'({valid, busy, count}), 32'(held));
      end
      start = 1'b0;
      ready = 1'b1;
      tick(1);
      check("bp_idle_busy", 32'(busy), 0);
      check("bp_idle_valid", 32'(valid), 0);
      tick(5);
      check("bp_start_ignored", 32'(busy), 0);

      // Randomized periods and selections.
      for (int k = 0; k < 6; k++) begin
         halfNs0 = $urandom_range(12, 60);
         halfNs1 = $urandom_range(12, 60);
         tick(8);
         startMeas(1'($urandom_range(0, 1)));
         waitIdle("rand_done", 200);
      end

      // Reset mid-MEASURE.
      startMeas(1'b0);
      tick(40);
      reset = 1'b1;
      #1;
      check("mid_rst_roEn", 32'(roEn), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_valid", 32'(valid), 0);
      check("mid_rst_count", 32'(count), 0);
      sbq.delete();
      tick(1);
      reset = 1'b0;
      validAfter = 0;
      for (int i = 0; i < 120; i++) begin
         tick(1);
         if (valid) validAfter++;
      end
      check("no_valid_after_rst", validAfter, 0);

      // Saturation: 4-bit counter, input period 2 clocks.
      satStart = 1'b1;
      tick(1);
      satStart = 1'b0;
      for (int i = 0; i < 200 && !satValid; i++) tick(1);
      check("sat_valid", 32'(satValid), 1);
      check("sat_count", 32'(satCount), 15);
      check("sat_overflow", 32'(satOverflow), 1);
      tick(2);

      // Out-of-range index on a 3-input meter is ignored; the top valid index works.
      invSel   = 2'd3;
      invStart = 1'b1;
      tick(1);
      invStart = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("inv_busy", 32'(invBusy), 0);
         check("inv_roEn", 32'(invRoEn), 0);
         tick(1);
      end
      invSel   = 2'd2;
      invStart = 1'b1;
      tick(1);
      invStart = 1'b0;
      tick(3);
      check("inv_sel2_roEn", 32'(invRoEn), 32'b100);

      check("roEn_onehot", onehotBad, 0);
      check("scoreboard_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
